// File: rtl/hps_ext_pkg.sv
// Shared EXT_BUS field positions, default command codes and bus FSM states
// for the HPS<->core mailbox.
package hps_ext_pkg;

  localparam int unsigned DOUT_LSB = 0;
  localparam int unsigned DIN_LSB  = 16;
  localparam int unsigned DOUT_EN  = 32;
  localparam int unsigned STROBE   = 33;
  localparam int unsigned ENABLE   = 34;

  localparam logic [15:0] CMD_GET_DEF = 16'h0034;
  localparam logic [15:0] CMD_SET_DEF = 16'h0035;

  localparam int unsigned WC_W = 10;

  // S_SYNC: out of reset, waiting to see io_enable low before trusting strobes.
  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_CMD,
    S_DATA
  } bus_state_e;

endpackage

// File: rtl/hps_ext_fifo.sv
// Synchronous show-ahead FIFO holding queued core->HPS messages.
module hps_ext_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hps_ext_mailbox.sv
// HPS<->core message bridge on EXT_BUS: queued core->HPS messages drained by
// CMD_GET, HPS->core messages posted by CMD_SET and delivered as an rx pulse.
module hps_ext_mailbox
  import hps_ext_pkg::*;
#(
  parameter int unsigned MSG_WORDS  = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] CMD_GET    = CMD_GET_DEF,
  parameter logic [15:0] CMD_SET    = CMD_SET_DEF
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  inout  wire  [35:0]                   EXT_BUS,
  input  logic                          tx_valid,
  input  logic [16*MSG_WORDS-1:0]       tx_data,
  output logic                          tx_ready,
  output logic                          tx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          rx_valid,
  output logic [16*MSG_WORDS-1:0]       rx_data
);

  localparam int unsigned MW = 16 * MSG_WORDS;

  logic [15:0]     io_din;
  logic            io_strobe;
  logic            io_enable;
  logic            unused_bus;

  bus_state_e      state_q;
  logic [WC_W-1:0] wc_q;
  logic [15:0]     cmd_q;
  logic [15:0]     dout_q;
  logic            dout_en_q;
  logic [MW-1:0]   shadow_q;
  logic [MW-1:0]   rx_data_q;
  logic            rx_valid_q;
  logic            pop_q;
  logic            ovf_q;
  logic [7:0]      seq_q;

  logic [MW-1:0]   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic [15:0]     rd_word;
  logic            frame_done;

  assign io_din    = EXT_BUS[DIN_LSB +: 16];
  assign io_strobe = EXT_BUS[STROBE];
  assign io_enable = EXT_BUS[ENABLE];
  assign unused_bus = ^{EXT_BUS[35], EXT_BUS[DOUT_EN], EXT_BUS[DOUT_LSB +: 16]};

  assign EXT_BUS[DOUT_LSB +: 16] = dout_q;
  assign EXT_BUS[DOUT_EN]        = dout_en_q;

  assign tx_ready    = !fifo_full;
  assign push        = tx_valid && !fifo_full;
  assign tx_overflow = ovf_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign frame_done  = (wc_q > WC_W'(MSG_WORDS));

  hps_ext_fifo #(
    .WIDTH (MW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (tx_data),
    .pop_i   (pop_q),
    .head_o  (head),
    .count_o (tx_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rd_word = '0;
    if (cmd_q == CMD_GET && !fifo_empty) begin
      for (int unsigned i = 0; i < MSG_WORDS; i++) begin
        if (wc_q == WC_W'(i + 1)) rd_word = head[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_SYNC;
      wc_q       <= '0;
      cmd_q      <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      shadow_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      pop_q      <= 1'b0;
      ovf_q      <= 1'b0;
      seq_q      <= '0;
    end else begin
      pop_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      ovf_q      <= tx_valid && fifo_full;
      if (push) seq_q <= seq_q + 8'd1;

      if (!io_enable) begin
        // Commit happens only on the enable fall of a fully strobed frame.
        if ((state_q == S_CMD || state_q == S_DATA) && frame_done) begin
          if (cmd_q == CMD_GET && !fifo_empty) pop_q <= 1'b1;
          if (cmd_q == CMD_SET) begin
            rx_data_q  <= shadow_q;
            rx_valid_q <= 1'b1;
          end
        end
        state_q   <= S_IDLE;
        wc_q      <= '0;
        dout_q    <= '0;
        dout_en_q <= 1'b0;
      end else if (state_q != S_SYNC) begin
        if (state_q == S_IDLE) state_q <= S_CMD;
        if (io_strobe) begin
          if (wc_q == '0) begin
            cmd_q     <= io_din;
            dout_en_q <= (io_din == CMD_GET) || (io_din == CMD_SET);
            dout_q    <= (io_din == CMD_GET) ? {8'(tx_count), seq_q} : 16'h0000;
            state_q   <= S_DATA;
          end else begin
            dout_q <= rd_word;
            if (cmd_q == CMD_SET) begin
              for (int unsigned i = 0; i < MSG_WORDS; i++) begin
                if (wc_q == WC_W'(i + 1)) shadow_q[16*i +: 16] <= io_din;
              end
            end
          end
          if (wc_q != '1) wc_q <= wc_q + WC_W'(1);
        end
      end
    end
  end

endmodule
